// File: rtl/fifo_stream_pkg.sv
// Purpose: shared state encoding and default buffer depth for the FIFO read streamer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } stream_state_t;

    // Smallest depth that still sustains one word per cycle across the
    // one-cycle FIFO read latency (one word buffered + one in flight + slack).
    localparam int SKID_DEPTH_DEFAULT = 3;

endpackage

// File: rtl/fifo_skid_buf.sv
// Purpose: small circular output buffer between the FIFO read port and the stream.
// Latency: a pushed word is visible on head_data the cycle after the push.
// Backpressure: push is ignored when full (unless popping); pop is ignored when empty.
module fifo_skid_buf #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 3,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [OCC_W-1:0] occ
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap from the last entry back to zero (depth need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_ok    = pop && (occ != '0);
    assign push_ok   = push && ((occ != OCC_W'(DEPTH)) || pop_ok);
    assign head_data = mem[rd_ptr];

    // Storage is cleared on reset so no stale word can reach the head after restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave occ unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_streamer.sv
// Purpose: drains an upstream FIFO into a valid/ready stream; FIFO_RD_STREAMER_STATS_EN adds xfer_cnt.
// Latency: first word on m_data three cycles after en rises (IDLE->RUN, read, capture); then 1 word/cycle.
// Backpressure: reads are throttled by buffer room (occ + inflight), never by m_ready directly.
module fifo_rd_streamer
    import fifo_stream_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int SKID_DEPTH = SKID_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  err_underflow
`ifdef FIFO_RD_STREAMER_STATS_EN
    ,
    output logic [31:0]           xfer_cnt
`endif
);

    localparam int OCC_W = $clog2(SKID_DEPTH + 1);

    stream_state_t    state;
    stream_state_t    state_nxt;
    logic             inflight;
    logic [OCC_W-1:0] occ;
    logic             xfer;

    assign m_valid = (occ != '0);
    assign xfer    = m_valid && m_ready;

    fifo_skid_buf #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (fifo_data_out),
        .pop       (xfer),
        .head_data (m_data),
        .occ       (occ)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus read issue; a read is only issued when the buffer can
    // absorb it even if the word already in flight also lands.
    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (en) state_nxt = RUN;
            end
            RUN: begin
                fifo_rd_en = !fifo_empty && ((int'(occ) + int'(inflight)) < SKID_DEPTH);
                if (!en) state_nxt = STOP;
            end
            STOP: begin
                if (en) begin
                    state_nxt = RUN;
                end else if (!inflight && (occ == '0)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read data arrives one cycle after the strobe; remember that it is coming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_underflow <= 1'b0;
        end else if (fifo_underflow) begin
            err_underflow <= 1'b1;
        end
    end

`ifdef FIFO_RD_STREAMER_STATS_EN
    // Count completed output transfers; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (xfer) begin
            xfer_cnt <= xfer_cnt + 32'd1;
        end
    end
`endif

endmodule
